// File: rtl/fir_pkg.sv
// Shared widths, tap geometry and the default passthrough kernel for the
// fir_filter convolution stage.
package fir_pkg;

   localparam int NTAPS         = 25;
   localparam int NROWS         = 5;
   localparam int PIX_W         = 8;
   localparam int COEF_W        = 8;
   localparam int PROD_W        = 17;
   localparam int ROW_W         = 20;
   localparam int ACC_W         = 22;
   localparam int CENTRE_TAP    = 12;
   localparam int LAT           = 5;
   localparam int DEFAULT_SHIFT = 4;

   typedef logic [PIX_W-1:0]         pix_t;
   typedef logic signed [COEF_W-1:0] coef_t;

   typedef enum logic {
      COEF_IDLE    = 1'b0,
      COEF_PENDING = 1'b1
   } coef_state_e;

   // Default kernel: unity gain at the centre tap, zero elsewhere.
   function automatic coef_t default_coef(input int tap, input int shift);
      if (tap == CENTRE_TAP) return coef_t'(1 << shift);
      return '0;
   endfunction

endpackage

// File: rtl/fir_mac_tree.sv
// Multiply/accumulate tree: 25 products, five row sums, rounded shift and
// saturation to an 8-bit pixel, one register stage per step.
module fir_mac_tree
   import fir_pkg::*;
#(
   parameter int SHIFT = DEFAULT_SHIFT
) (
   input  logic clk,
   input  logic rst,
   input  pix_t win_i  [NTAPS],
   input  coef_t coef_i [NTAPS],
   output pix_t pix_o
);

   localparam int ROUND = 1 << (SHIFT - 1);

   logic signed [PROD_W-1:0] prod_d [NTAPS];
   logic signed [PROD_W-1:0] prod_q [NTAPS];
   logic signed [ROW_W-1:0]  row_d  [NROWS];
   logic signed [ROW_W-1:0]  row_q  [NROWS];
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [ACC_W-1:0]  acc_d, acc_q;
   pix_t                     pix_d, pix_q;

   always_comb begin : products
      for (int t = 0; t < NTAPS; t++) begin
         prod_d[t] = PROD_W'($signed({1'b0, win_i[t]})) * PROD_W'(coef_i[t]);
      end
   end

   always_comb begin : row_sums
      for (int r = 0; r < NROWS; r++) begin
         row_d[r] = '0;
         for (int c = 0; c < NROWS; c++) begin
            row_d[r] = row_d[r] + ROW_W'(prod_q[r*NROWS + c]);
         end
      end
   end

   // Round half up, then arithmetic shift so negative totals floor correctly.
   always_comb begin : total_and_scale
      acc_sum = '0;
      for (int r = 0; r < NROWS; r++) begin
         acc_sum = acc_sum + ACC_W'(row_q[r]);
      end
      acc_d = (acc_sum + ACC_W'(ROUND)) >>> SHIFT;
   end

   always_comb begin : saturate
      if (acc_q < 0) begin
         pix_d = '0;
      end else if (acc_q > ACC_W'(255)) begin
         pix_d = 8'd255;
      end else begin
         pix_d = acc_q[PIX_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < NTAPS; t++) prod_q[t] <= '0;
         for (int r = 0; r < NROWS; r++) row_q[r] <= '0;
         acc_q <= '0;
         pix_q <= '0;
      end else begin
         prod_q <= prod_d;
         row_q  <= row_d;
         acc_q  <= acc_d;
         pix_q  <= pix_d;
      end
   end

   assign pix_o = pix_q;

endmodule

// File: rtl/fir_conv_5x5.sv
// 5x5 convolution stage: column window, sync delay line and double-buffered
// coefficient banks that swap only at frame start.
module fir_conv_5x5
   import fir_pkg::*;
#(
   parameter int SHIFT = DEFAULT_SHIFT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PIX_W-1:0]  p0,
   input  logic [PIX_W-1:0]  p1,
   input  logic [PIX_W-1:0]  p2,
   input  logic [PIX_W-1:0]  p3,
   input  logic [PIX_W-1:0]  p4,
   input  logic              dv_i,
   input  logic              hs_i,
   input  logic              vs_i,
   input  logic              coef_we,
   input  logic [4:0]        coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   input  logic              coef_commit,
   output logic [PIX_W-1:0]  r_o,
   output logic [PIX_W-1:0]  g_o,
   output logic [PIX_W-1:0]  b_o,
   output logic              dv_o,
   output logic              hs_o,
   output logic              vs_o,
   output logic              coef_pending
);

   // dv_i qualifies a column on the cycle it is high; there is no backpressure.
   pix_t           col_in   [NROWS];
   pix_t           win_d    [NTAPS];
   pix_t           win_q    [NTAPS];
   coef_t          shadow_d [NTAPS];
   coef_t          shadow_q [NTAPS];
   coef_t          active_d [NTAPS];
   coef_t          active_q [NTAPS];
   logic           dv_prev_q, vs_prev_q;
   logic           dv_rise, vs_rise;
   logic [LAT-1:0] dv_sr_d, dv_sr_q;
   logic [LAT-1:0] hs_sr_d, hs_sr_q;
   logic [LAT-1:0] vs_sr_d, vs_sr_q;
   coef_state_e    coef_state_d, coef_state_q;
   logic           copy_en;
   pix_t           pix_out;

   assign col_in[0] = p0;
   assign col_in[1] = p1;
   assign col_in[2] = p2;
   assign col_in[3] = p3;
   assign col_in[4] = p4;

   assign dv_rise = dv_i & ~dv_prev_q;
   assign vs_rise = vs_i & ~vs_prev_q;

   // Column 4 is the newest; the first column of a line fills every slot.
   always_comb begin : window_next
      win_d = win_q;
      if (dv_i) begin
         for (int r = 0; r < NROWS; r++) begin
            for (int c = 0; c < NROWS - 1; c++) begin
               win_d[r*NROWS + c] = dv_rise ? col_in[r] : win_q[r*NROWS + c + 1];
            end
            win_d[r*NROWS + NROWS - 1] = col_in[r];
         end
      end
   end

   always_comb begin : sync_next
      dv_sr_d = {dv_sr_q[LAT-2:0], dv_i};
      hs_sr_d = {hs_sr_q[LAT-2:0], hs_i};
      vs_sr_d = {vs_sr_q[LAT-2:0], vs_i};
   end

   always_ff @(posedge clk or negedge rst) begin : coef_state_reg
      if (!rst) begin
         coef_state_q <= COEF_IDLE;
      end else begin
         coef_state_q <= coef_state_d;
      end
   end

   // A commit coinciding with the frame edge is applied at once, never pending.
   always_comb begin : coef_next_state
      coef_state_d = coef_state_q;
      case (coef_state_q)
         COEF_IDLE:    if (coef_commit && !vs_rise) coef_state_d = COEF_PENDING;
         COEF_PENDING: if (vs_rise) coef_state_d = COEF_IDLE;
         default:      coef_state_d = COEF_IDLE;
      endcase
   end

   always_comb begin : coef_outputs
      coef_pending = (coef_state_q == COEF_PENDING);
      copy_en      = vs_rise && ((coef_state_q == COEF_PENDING) || coef_commit);
   end

   // The copy reads the registered shadow, so a same-cycle write lands in shadow only.
   always_comb begin : coef_banks
      shadow_d = shadow_q;
      if (copy_en) begin
         active_d = shadow_q;
      end else begin
         active_d = active_q;
      end
      if (coef_we && (coef_addr < 5'(NTAPS))) begin
         shadow_d[coef_addr] = coef_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < NTAPS; t++) begin
            win_q[t]    <= '0;
            shadow_q[t] <= default_coef(t, SHIFT);
            active_q[t] <= default_coef(t, SHIFT);
         end
         dv_prev_q <= 1'b0;
         vs_prev_q <= 1'b0;
         dv_sr_q   <= '0;
         hs_sr_q   <= '0;
         vs_sr_q   <= '0;
      end else begin
         win_q     <= win_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         dv_prev_q <= dv_i;
         vs_prev_q <= vs_i;
         dv_sr_q   <= dv_sr_d;
         hs_sr_q   <= hs_sr_d;
         vs_sr_q   <= vs_sr_d;
      end
   end

   fir_mac_tree #(
      .SHIFT (SHIFT)
   ) u_mac_tree (
      .clk    (clk),
      .rst    (rst),
      .win_i  (win_q),
      .coef_i (active_q),
      .pix_o  (pix_out)
   );

   assign r_o  = pix_out;
   assign g_o  = pix_out;
   assign b_o  = pix_out;
   assign dv_o = dv_sr_q[LAT-1];
   assign hs_o = hs_sr_q[LAT-1];
   assign vs_o = vs_sr_q[LAT-1];

endmodule

// File: tb/tb_fir_conv_5x5.sv
// Bench for fir_conv_5x5: a reference window/kernel model feeds an expected
// pixel queue and a sync history, both checked every cycle at the falling edge.
module tb_fir_conv_5x5;
   import fir_pkg::*;

   localparam int SHIFT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  p0, p1, p2, p3, p4;
   logic        dv_i, hs_i, vs_i;
   logic        coef_we, coef_commit;
   logic [4:0]  coef_addr;
   logic [7:0]  coef_data;
   logic [7:0]  r_o, g_o, b_o;
   logic        dv_o, hs_o, vs_o, coef_pending;

   fir_conv_5x5 #(.SHIFT(SHIFT)) dut (
      .clk          (clk),
      .rst          (rst_n),
      .p0           (p0),
      .p1           (p1),
      .p2           (p2),
      .p3           (p3),
      .p4           (p4),
      .dv_i         (dv_i),
      .hs_i         (hs_i),
      .vs_i         (vs_i),
      .coef_we      (coef_we),
      .coef_addr    (coef_addr),
      .coef_data    (coef_data),
      .coef_commit  (coef_commit),
      .r_o          (r_o),
      .g_o          (g_o),
      .b_o          (b_o),
      .dv_o         (dv_o),
      .hs_o         (hs_o),
      .vs_o         (vs_o),
      .coef_pending (coef_pending)
   );

   // ---------------- clock / reset / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- drive state and reference model ----------------
   logic       d_dv = 1'b0, d_hs = 1'b0, d_vs = 1'b0, d_we = 1'b0, d_commit = 1'b0;
   logic [4:0] d_addr = '0;
   logic [7:0] d_data = '0;
   logic [7:0] d_p [5];

   int         m_win    [NTAPS];
   int         m_shadow [NTAPS];
   int         m_active [NTAPS];
   bit         m_pending, m_dv_prev, m_vs_prev;

   logic [7:0] exp_q  [$];
   logic [2:0] sync_q [$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int t = 0; t < NTAPS; t++) begin
         m_win[t]    = 0;
         m_shadow[t] = (t == CENTRE_TAP) ? (1 << SHIFT) : 0;
         m_active[t] = m_shadow[t];
      end
      m_pending = 0;
      m_dv_prev = 0;
      m_vs_prev = 0;
      exp_q.delete();
      sync_q.delete();
      repeat (LAT) sync_q.push_back(3'b000);
   endtask

   function automatic logic [7:0] conv_exp();
      int acc = 0;
      for (int t = 0; t < NTAPS; t++) acc += m_win[t] * m_active[t];
      acc = (acc + (1 << (SHIFT - 1))) >>> SHIFT;
      if (acc < 0) return 8'd0;
      if (acc > 255) return 8'd255;
      return acc[7:0];
   endfunction

   // ---------------- scoreboard ----------------
   task automatic sample_check();
      logic [2:0] s;
      logic [7:0] e;
      s = sync_q.pop_front();
      check_eq("dv_o", dv_o, s[0]);
      check_eq("hs_o", hs_o, s[1]);
      check_eq("vs_o", vs_o, s[2]);
      check_eq("coef_pending", coef_pending, m_pending);
      if (dv_o === 1'b1) begin
         check_eq("sb_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("r_o", r_o, e);
            check_eq("g_o", g_o, e);
            check_eq("b_o", b_o, e);
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic apply();
      bit vs_rise, dv_rise;
      p0 = d_p[0]; p1 = d_p[1]; p2 = d_p[2]; p3 = d_p[3]; p4 = d_p[4];
      dv_i = d_dv; hs_i = d_hs; vs_i = d_vs;
      coef_we = d_we; coef_addr = d_addr; coef_data = d_data; coef_commit = d_commit;

      vs_rise = d_vs && !m_vs_prev;
      dv_rise = d_dv && !m_dv_prev;
      if (vs_rise && (m_pending || d_commit)) begin
         m_active  = m_shadow;
         m_pending = 0;
      end else if (d_commit) begin
         m_pending = 1;
      end
      if (d_dv) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
               m_win[r*5 + c] = (dv_rise || c == 4) ? int'(d_p[r]) : m_win[r*5 + c + 1];
            end
         end
         exp_q.push_back(conv_exp());
      end
      if (d_we && d_addr < 5'(NTAPS)) m_shadow[d_addr] = int'($signed(d_data));
      sync_q.push_back({d_vs, d_hs, d_dv});
      m_dv_prev = d_dv;
      m_vs_prev = d_vs;
   endtask

   task automatic tick();
      @(negedge clk);
      sample_check();
      apply();
   endtask

   task automatic idle(input int n);
      d_dv = 1'b0;
      repeat (n) tick();
   endtask

   task automatic stream_const(input int n, input logic [7:0] v);
      d_dv = 1'b1;
      for (int r = 0; r < 5; r++) d_p[r] = v;
      repeat (n) tick();
   endtask

   task automatic stream_rand(input int n);
      d_dv = 1'b1;
      repeat (n) begin
         for (int r = 0; r < 5; r++) d_p[r] = 8'($urandom_range(0, 255));
         tick();
      end
   endtask

   task automatic wr(input int a, input int v);
      d_we   = 1'b1;
      d_addr = a[4:0];
      d_data = v[7:0];
      tick();
      d_we   = 1'b0;
   endtask

   task automatic commit_then_vs();
      d_commit = 1'b1; tick(); d_commit = 1'b0;
      idle(2);
      d_vs = 1'b1; tick(); d_vs = 1'b0;
      idle(1);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_r"}, r_o, 0);
      check_eq({tag, "_g"}, g_o, 0);
      check_eq({tag, "_b"}, b_o, 0);
      check_eq({tag, "_dv"}, dv_o, 0);
      check_eq({tag, "_hs"}, hs_o, 0);
      check_eq({tag, "_vs"}, vs_o, 0);
      check_eq({tag, "_pending"}, coef_pending, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int r = 0; r < 5; r++) d_p[r] = 8'd0;
      p0 = '0; p1 = '0; p2 = '0; p3 = '0; p4 = '0;
      dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
      model_reset();

      @(negedge clk);
      check_all_zero("reset");
      tick();
      rst_n = 1'b1;
      idle(2);

      // Default kernel, dv pattern 1,1,0,1 with random syncs
      for (int r = 0; r < 5; r++) d_p[r] = 8'd100;
      for (int i = 0; i < 4; i++) begin
         d_dv = (i != 2);
         d_hs = 1'($urandom_range(0, 1));
         d_vs = 1'($urandom_range(0, 1));
         tick();
      end
      d_hs = 1'b0; d_vs = 1'b0;
      idle(LAT + 2);
      for (int i = 0; i < 20; i++) begin
         d_dv = 1'($urandom_range(0, 1));
         d_hs = 1'($urandom_range(0, 1));
         for (int r = 0; r < 5; r++) d_p[r] = 8'($urandom_range(0, 255));
         tick();
      end
      d_hs = 1'b0;
      idle(LAT + 2);

      // All-ones kernel: 100 -> 156, 200 -> saturates at 255
      for (int t = 0; t < NTAPS; t++) wr(t, 1);
      commit_then_vs();
      stream_const(8, 8'd100);
      idle(LAT + 1);
      stream_const(8, 8'd200);
      idle(LAT + 1);

      // Centre -16: negative result saturates to 0; out-of-range address ignored
      for (int t = 0; t < NTAPS; t++) wr(t, (t == CENTRE_TAP) ? -16 : 0);
      wr(27, 99);
      commit_then_vs();
      stream_const(8, 8'd50);
      idle(LAT + 1);

      // Mid-frame commit: old kernel (gain 1/2) holds until the next vs edge
      wr(CENTRE_TAP, 8);
      commit_then_vs();
      stream_rand(6);
      d_dv = 1'b1;
      d_we = 1'b1; d_addr = 5'(CENTRE_TAP); d_data = 8'd16; d_commit = 1'b1;
      for (int r = 0; r < 5; r++) d_p[r] = 8'($urandom_range(0, 255));
      tick();
      d_we = 1'b0; d_commit = 1'b0;
      stream_rand(8);
      d_vs = 1'b1;
      d_we = 1'b1; d_addr = 5'(CENTRE_TAP); d_data = 8'd32;
      for (int r = 0; r < 5; r++) d_p[r] = 8'($urandom_range(0, 255));
      tick();
      d_we = 1'b0;
      stream_rand(8);
      d_vs = 1'b0;
      stream_rand(3);
      // Commit coincident with the vs edge applies immediately (gain 2)
      d_commit = 1'b1; d_vs = 1'b1;
      for (int r = 0; r < 5; r++) d_p[r] = 8'($urandom_range(0, 255));
      tick();
      d_commit = 1'b0;
      stream_rand(8);
      d_vs = 1'b0;
      idle(LAT + 1);

      // Left-edge replication with tap 10 only
      wr(CENTRE_TAP, 0);
      wr(10, 16);
      d_commit = 1'b1; d_vs = 1'b1; tick();
      d_commit = 1'b0; d_vs = 1'b0;
      idle(2);
      stream_const(1, 8'd10);
      stream_const(1, 8'd20);
      stream_const(1, 8'd30);
      idle(LAT + 1);

      // Asynchronous reset mid-line with data in flight and a pending commit
      d_commit = 1'b1; tick(); d_commit = 1'b0;
      stream_rand(4);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      model_reset();
      d_dv = 1'b0; d_hs = 1'b0; d_vs = 1'b0; d_we = 1'b0; d_commit = 1'b0;
      tick();
      rst_n = 1'b1;
      idle(8);
      stream_const(6, 8'd100);
      idle(LAT + 2);

      check_eq("sb_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
